// File: rtl/vit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vit_pkg
// Description : Types and helpers shared by the Viterbi decoder blocks:
//               path/branch metric types, trellis state type, scheduler
//               FSM encoding and the rate-1/2 encoder codeword function.
// Revision    : 1.0 - initial release
// ============================================================================
package vit_pkg;

    // Constraint length the shared types and helpers are sized for.
    localparam int VIT_K = 4;

    typedef logic [7:0]       pm_t;     // path metric, 8-bit modular
    typedef logic [1:0]       bm_t;     // branch metric
    typedef logic [VIT_K-2:0] state_t;  // trellis state index

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACS  = 2'd1,
        EMIT = 2'd2
    } sched_state_e;

    // Encoder output for input bit u leaving predecessor state pred.
    // The encoder register is {u, pred}; bit K-1 holds the newest input.
    // Result is {bit from g0, bit from g1}, i.e. the branch-metric index.
    function automatic logic [1:0] codeword(
        input logic             u,
        input logic [VIT_K-2:0] pred,
        input logic [VIT_K-1:0] g0,
        input logic [VIT_K-1:0] g1
    );
        logic [VIT_K-1:0] enc;
        enc = {u, pred};
        return {^(enc & g0), ^(enc & g1)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/acs_scheduler_acs.sv
`default_nettype none
// ============================================================================
// Module      : acs_scheduler_acs
// Description : Combinational add-compare-select for one trellis state.
//               Adds each branch metric to its predecessor path metric and
//               keeps the cheaper valid path.
// Ports       : path0_pmc/path0_valid/bmc0 - predecessor with LSB 0
//               path1_pmc/path1_valid/bmc1 - predecessor with LSB 1
//               path_cost  - surviving path metric (0 when none valid)
//               valid_o    - at least one predecessor was valid
//               selection  - 1 when the LSB-1 predecessor survives
// Revision    : 1.0 - initial release
// ============================================================================
module acs_scheduler_acs
    import vit_pkg::*;
(
    input  pm_t  path0_pmc,
    input  logic path0_valid,
    input  bm_t  bmc0,
    input  pm_t  path1_pmc,
    input  logic path1_valid,
    input  bm_t  bmc1,
    output pm_t  path_cost,
    output logic valid_o,
    output logic selection
);

    pm_t w_cost0;
    pm_t w_cost1;

    assign w_cost0 = path0_pmc + {6'd0, bmc0};
    assign w_cost1 = path1_pmc + {6'd0, bmc1};

    always_comb begin
        path_cost = '0;
        valid_o   = 1'b0;
        selection = 1'b0;
        if (path0_valid && path1_valid) begin
            valid_o = 1'b1;
            // Equal costs keep path 0.
            if (w_cost1 < w_cost0) begin
                selection = 1'b1;
                path_cost = w_cost1;
            end else begin
                path_cost = w_cost0;
            end
        end else if (path0_valid) begin
            valid_o   = 1'b1;
            path_cost = w_cost0;
        end else if (path1_valid) begin
            valid_o   = 1'b1;
            selection = 1'b1;
            path_cost = w_cost1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/acs_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : acs_scheduler
// Description : Time-multiplexes one ACS unit over all 2**(K-1) trellis
//               states of a rate-1/2 Viterbi decoder. Keeps ping-pong path
//               metric banks and emits one decision vector per symbol with
//               the best state and its metric.
// Ports       : clk, rst_n          - clock, async active-low reset
//               init                - restart trellis (honoured in IDLE only)
//               bm_valid/bm_ready/bm- branch metrics, bm[c] for codeword c
//               dec_valid/dec_ready - decision vector handshake
//               dec_bits            - per-state ACS selection
//               best_state/best_pm  - minimum new path metric, lowest index
//               busy                - high while in ACS or EMIT
// Revision    : 1.0 - initial release
// ============================================================================
module acs_scheduler
    import vit_pkg::*;
#(
    parameter int           K  = 4,
    parameter logic [K-1:0] G0 = 4'b1101,
    parameter logic [K-1:0] G1 = 4'b1111
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init,
    input  logic                  bm_valid,
    output logic                  bm_ready,
    input  bm_t  [3:0]            bm,
    output logic                  dec_valid,
    input  logic                  dec_ready,
    output logic [2**(K-1)-1:0]   dec_bits,
    output logic [K-2:0]          best_state,
    output pm_t                   best_pm,
    output logic                  busy
);

    localparam int NUM_STATES = 2**(K-1);
    // Only state 0 is reachable right after a restart.
    localparam logic [NUM_STATES-1:0] INIT_VALID = {{(NUM_STATES-1){1'b0}}, 1'b1};

    sched_state_e            r_state;
    logic [K-2:0]            r_cnt;
    logic                    r_sel;          // bank currently read
    logic                    r_norm;         // subtract 128 on read this symbol
    bm_t  [3:0]              r_bm;
    pm_t                     r_pm [2][NUM_STATES];
    logic [NUM_STATES-1:0]   r_v  [2];
    logic [NUM_STATES-1:0]   r_dec_acc;
    pm_t                     r_min_pm;
    logic [K-2:0]            r_min_st;
    logic                    r_found;
    logic                    r_all_msb;

    logic                    w_wr_sel;
    logic                    w_u;
    logic [K-2:0]            w_p0;
    logic [K-2:0]            w_p1;
    pm_t                     w_pm0;
    pm_t                     w_pm1;
    logic                    w_v0;
    logic                    w_v1;
    bm_t                     w_bmc0;
    bm_t                     w_bmc1;
    pm_t                     w_cost;
    logic                    w_valid;
    logic                    w_sel;
    logic                    w_take;
    pm_t                     w_min_pm_n;
    logic [K-2:0]            w_min_st_n;
    logic                    w_all_msb_n;

    // A new symbol is only taken in IDLE and never in the cycle init is seen.
    assign bm_ready = (r_state == IDLE) && !init;
    assign w_wr_sel = ~r_sel;

    // Predecessors of state s are {s[K-3:0], b}; the input bit is s[K-2].
    assign w_u  = r_cnt[K-2];
    assign w_p0 = {r_cnt[K-3:0], 1'b0};
    assign w_p1 = {r_cnt[K-3:0], 1'b1};

    always_comb begin
        w_pm0  = r_pm[r_sel][w_p0];
        w_pm1  = r_pm[r_sel][w_p1];
        w_v0   = r_v[r_sel][w_p0];
        w_v1   = r_v[r_sel][w_p1];
        // All valid metrics had their MSB set last symbol, so clearing it
        // is an exact subtraction of 128.
        if (r_norm) begin
            w_pm0[7] = 1'b0;
            w_pm1[7] = 1'b0;
        end
        w_bmc0 = r_bm[codeword(w_u, w_p0, G0, G1)];
        w_bmc1 = r_bm[codeword(w_u, w_p1, G0, G1)];
    end

    acs_scheduler_acs u_acs (
        .path0_pmc   (w_pm0),
        .path0_valid (w_v0),
        .bmc0        (w_bmc0),
        .path1_pmc   (w_pm1),
        .path1_valid (w_v1),
        .bmc1        (w_bmc1),
        .path_cost   (w_cost),
        .valid_o     (w_valid),
        .selection   (w_sel)
    );

    // Running minimum and MSB tracking including the state written now.
    // States are visited in ascending order, so strict < keeps the lowest.
    always_comb begin
        w_take      = w_valid && (!r_found || (w_cost < r_min_pm));
        w_min_pm_n  = w_take ? w_cost : r_min_pm;
        w_min_st_n  = w_take ? r_cnt  : r_min_st;
        w_all_msb_n = r_all_msb && (!w_valid || w_cost[7]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_sel      <= 1'b0;
            r_norm     <= 1'b0;
            r_bm       <= '0;
            for (int b = 0; b < 2; b++) begin
                r_v[b] <= INIT_VALID;
                for (int i = 0; i < NUM_STATES; i++) begin
                    r_pm[b][i] <= '0;
                end
            end
            r_dec_acc  <= '0;
            r_min_pm   <= '0;
            r_min_st   <= '0;
            r_found    <= 1'b0;
            r_all_msb  <= 1'b1;
            dec_valid  <= 1'b0;
            dec_bits   <= '0;
            best_state <= '0;
            best_pm    <= '0;
            busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (init) begin
                        for (int i = 0; i < NUM_STATES; i++) begin
                            r_pm[r_sel][i] <= '0;
                        end
                        r_v[r_sel] <= INIT_VALID;
                        r_norm     <= 1'b0;
                    end else if (bm_valid) begin
                        r_bm      <= bm;
                        r_cnt     <= '0;
                        r_found   <= 1'b0;
                        r_all_msb <= 1'b1;
                        busy      <= 1'b1;
                        r_state   <= ACS;
                    end
                end
                ACS: begin
                    r_pm[w_wr_sel][r_cnt] <= w_cost;
                    r_v[w_wr_sel][r_cnt]  <= w_valid;
                    r_dec_acc[r_cnt]      <= w_sel;
                    r_min_pm              <= w_min_pm_n;
                    r_min_st              <= w_min_st_n;
                    r_found               <= r_found | w_valid;
                    r_all_msb             <= w_all_msb_n;
                    if (&r_cnt) begin
                        r_sel   <= w_wr_sel;
                        r_norm  <= w_all_msb_n;
                        r_state <= EMIT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                EMIT: begin
                    // First EMIT cycle loads the output registers; they then
                    // hold until the traceback takes them.
                    if (!dec_valid) begin
                        dec_valid  <= 1'b1;
                        dec_bits   <= r_dec_acc;
                        best_state <= r_min_st;
                        best_pm    <= r_min_pm;
                    end else if (dec_ready) begin
                        dec_valid <= 1'b0;
                        busy      <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_acs_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_acs_scheduler
// Description : Self-checking bench for acs_scheduler. A forward trellis
//               model (per predecessor, per input bit) predicts decisions,
//               best state and best metric for every symbol.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_acs_scheduler;
    import vit_pkg::*;

    localparam int NS = 8;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             init      = 1'b0;
    logic             bm_valid  = 1'b0;
    logic             dec_ready = 1'b0;
    logic [3:0][1:0]  bm        = '0;
    logic             bm_ready;
    logic             dec_valid;
    logic             busy;
    logic [NS-1:0]    dec_bits;
    state_t           best_state;
    logic [7:0]       best_pm;

    int n_checks = 0;
    int n_errors = 0;

    // Reference trellis state.
    int m_pm [NS];
    bit m_v  [NS];
    bit m_norm;
    int m_dec;
    int m_best_st;
    int m_best_pm;

    typedef struct {
        bit         do_init;
        logic [7:0] bmw;
        int         exp_st;
        int         exp_pm;
        int         exp_dec;   // -1: decisions checked against model only
    } vec_t;

    vec_t tbl [12];

    always #5 clk = ~clk;

    acs_scheduler #(.K(4), .G0(4'b1101), .G1(4'b1111)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .init       (init),
        .bm_valid   (bm_valid),
        .bm_ready   (bm_ready),
        .bm         (bm),
        .dec_valid  (dec_valid),
        .dec_ready  (dec_ready),
        .dec_bits   (dec_bits),
        .best_state (best_state),
        .best_pm    (best_pm),
        .busy       (busy)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_init();
        for (int s = 0; s < NS; s++) begin
            m_pm[s] = 0;
            m_v[s]  = (s == 0);
        end
        m_norm = 1'b0;
    endfunction

    // Extend every surviving path by both input bits; keep the cheapest
    // arrival per next state, first (even predecessor) winning ties.
    function automatic void model_step(input logic [7:0] bmw);
        int npm [NS];
        bit nv  [NS];
        int dec, base, enc, cw, cost, nxt;
        dec = 0;
        for (int s = 0; s < NS; s++) begin
            npm[s] = 0;
            nv[s]  = 1'b0;
        end
        for (int p = 0; p < NS; p++) begin
            if (m_v[p]) begin
                base = m_pm[p] - (m_norm ? 128 : 0);
                for (int u = 0; u < 2; u++) begin
                    enc  = u * 8 + p;
                    cw   = 2 * ($countones(enc & 'hD) % 2) + ($countones(enc & 'hF) % 2);
                    cost = base + int'(bmw[2*cw +: 2]);
                    nxt  = u * 4 + p / 2;
                    if (!nv[nxt] || cost < npm[nxt]) begin
                        npm[nxt] = cost;
                        nv[nxt]  = 1'b1;
                        if (p % 2 == 1) dec = dec | (1 << nxt);
                        else            dec = dec & ~(1 << nxt);
                    end
                end
            end
        end
        m_norm    = 1'b1;
        m_best_st = -1;
        m_best_pm = 0;
        for (int s = 0; s < NS; s++) begin
            if (nv[s]) begin
                if (npm[s] < 128) m_norm = 1'b0;
                if (m_best_st < 0 || npm[s] < m_best_pm) begin
                    m_best_st = s;
                    m_best_pm = npm[s];
                end
            end
            m_pm[s] = npm[s];
            m_v[s]  = nv[s];
        end
        m_dec = dec;
    endfunction

    task automatic do_init();
        @(negedge clk);
        init = 1'b1;
        #1;
        check("init_bm_ready", int'(bm_ready), 0);
        @(posedge clk);
        #1;
        init = 1'b0;
        model_init();
    endtask

    // One full symbol: offer bm, measure latency, compare against the model,
    // optionally hold dec_ready low (poking bm_valid), then hand shake.
    task automatic do_step(input logic [7:0] bmw, input int hold, input bit poke,
                           output int got_st, output int got_pm, output int got_dec);
        int t;
        int lat;
        got_st  = -1;
        got_pm  = -1;
        got_dec = -1;
        @(negedge clk);
        t = 0;
        while (!bm_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!bm_ready) begin
            check("bm_ready_timeout", 0, 1);
            return;
        end
        bm       = bmw;
        bm_valid = 1'b1;
        @(posedge clk);
        #1;
        bm_valid = 1'b0;
        bm       = 8'($urandom);
        check("busy_after_accept", int'(busy), 1);
        model_step(bmw);
        lat = 0;
        while (!dec_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, 9);
        if (!dec_valid) return;
        check("dec_bits", int'(dec_bits), m_dec);
        check("best_state", int'(best_state), m_best_st);
        check("best_pm", int'(best_pm), m_best_pm);
        got_st  = int'(best_state);
        got_pm  = int'(best_pm);
        got_dec = int'(dec_bits);
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                bm_valid = 1'b1;
                bm       = 8'($urandom);
            end
            @(posedge clk);
            #1;
            check("hold_dec_valid", int'(dec_valid), 1);
            check("hold_bm_ready", int'(bm_ready), 0);
            check("hold_dec_bits", int'(dec_bits), got_dec);
            check("hold_best_state", int'(best_state), got_st);
            check("hold_best_pm", int'(best_pm), got_pm);
        end
        bm_valid  = 1'b0;
        dec_ready = 1'b1;
        @(posedge clk);
        #1;
        dec_ready = 1'b0;
        check("post_hs_dec_valid", int'(dec_valid), 0);
        check("post_hs_bm_ready", int'(bm_ready), 1);
        check("post_hs_busy", int'(busy), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st, pm, dec;
        logic [7:0] rb;

        // bm packed {c3,c2,c1,c0}: 8'h94 = {2,1,1,0} is the all-zero pattern.
        tbl[0]  = '{1'b1, 8'h94, 0, 0, -1};
        tbl[1]  = '{1'b0, 8'h94, 0, 0, -1};
        tbl[2]  = '{1'b0, 8'h94, 0, 0, -1};
        tbl[3]  = '{1'b0, 8'h94, 0, 0, -1};
        tbl[4]  = '{1'b0, 8'h94, 0, 0, -1};
        tbl[5]  = '{1'b0, 8'h94, 0, 0, -1};
        tbl[6]  = '{1'b1, 8'h55, 0, 1, 0};
        tbl[7]  = '{1'b0, 8'h55, 0, 2, 0};
        tbl[8]  = '{1'b0, 8'h55, 0, 3, 0};
        tbl[9]  = '{1'b0, 8'h55, 0, 4, 0};
        tbl[10] = '{1'b1, 8'hAA, 0, 2, 0};
        tbl[11] = '{1'b0, 8'hAA, 0, 4, 0};

        // Reset values.
        model_init();
        repeat (3) @(negedge clk);
        check("rst_bm_ready", int'(bm_ready), 1);
        check("rst_dec_valid", int'(dec_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_dec_bits", int'(dec_bits), 0);
        check("rst_best_state", int'(best_state), 0);
        check("rst_best_pm", int'(best_pm), 0);
        rst_n = 1'b1;

        // First step straight out of reset behaves like a fresh init.
        do_step(8'h94, 0, 1'b0, st, pm, dec);
        check("first_best_state", st, 0);
        check("first_best_pm", pm, 0);
        // Only states 0 and 4 were reachable: state 2 shows up next step.
        do_step(8'h94, 0, 1'b0, st, pm, dec);

        // Table-driven vectors.
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].do_init) do_init();
            do_step(tbl[i].bmw, 0, 1'b0, st, pm, dec);
            check("tbl_best_state", st, tbl[i].exp_st);
            check("tbl_best_pm", pm, tbl[i].exp_pm);
            if (tbl[i].exp_dec >= 0) check("tbl_dec_bits", dec, tbl[i].exp_dec);
        end

        // Backpressure with bm_valid poked while EMIT is held.
        do_step(8'h94, 5, 1'b1, st, pm, dec);
        do_step(8'h94, 0, 1'b0, st, pm, dec);

        // Normalisation: metrics grow by 3 per symbol until all reach 128.
        do_init();
        for (int i = 0; i < 50; i++) begin
            do_step(8'hFF, 0, 1'b0, st, pm, dec);
            if (i == 42) check("norm_pm_before", pm, 129);
            if (i == 43) check("norm_pm_after", pm, 4);
        end

        // Reset in the middle of an ACS pass.
        do_init();
        do_step(8'hAA, 0, 1'b0, st, pm, dec);
        do_step(8'hAA, 0, 1'b0, st, pm, dec);
        @(negedge clk);
        bm       = 8'h94;
        bm_valid = 1'b1;
        @(posedge clk);
        #1;
        bm_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_dec_valid", int'(dec_valid), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_bm_ready", int'(bm_ready), 1);
        check("midrst_dec_bits", int'(dec_bits), 0);
        check("midrst_best_state", int'(best_state), 0);
        check("midrst_best_pm", int'(best_pm), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_init();
        do_step(8'h94, 0, 1'b0, st, pm, dec);
        check("midrst_next_pm", pm, 0);
        do_step(8'h94, 0, 1'b0, st, pm, dec);

        // Randomized symbols, restarts and backpressure.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(7) == 0) do_init();
            rb = 8'($urandom);
            do_step(rb, int'($urandom_range(3)), 1'($urandom_range(1)), st, pm, dec);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
